// File: rtl/ysyx_25040105_pkg.sv
// ---- ysyx_25040105_pkg : shared types and constants for the exec sequencer (rev 1.0) ----
`default_nettype none

package ysyx_25040105_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_EXEC   = 3'd3,
    ST_COMMIT = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  localparam logic [1:0] HALT_NONE    = 2'd0;
  localparam logic [1:0] HALT_GOOD    = 2'd1;
  localparam logic [1:0] HALT_BAD     = 2'd2;
  localparam logic [1:0] HALT_TIMEOUT = 2'd3;

  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_NOP    = 32'h0000_0013;

endpackage

`default_nettype wire

// File: rtl/ysyx_25040105_perf_cnt.sv
// ---- ysyx_25040105_perf_cnt : 64-bit cycle and retired-instruction counters (rev 1.0) ----
`default_nettype none

module ysyx_25040105_perf_cnt (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        inc_cycle_i,
  input  logic        inc_inst_i,
  input  logic        freeze_i,
  output logic [63:0] cycle_cnt_o,
  output logic [63:0] instret_o
);

  logic [63:0] cycle_q;
  logic [63:0] instret_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cycle_q   <= 64'd0;
      instret_q <= 64'd0;
    end else if (!freeze_i) begin
      if (inc_cycle_i) cycle_q   <= cycle_q + 64'd1;
      if (inc_inst_i)  instret_q <= instret_q + 64'd1;
    end
  end

  assign cycle_cnt_o = cycle_q;
  assign instret_o   = instret_q;

endmodule

`default_nettype wire

// File: rtl/ysyx_25040105_exec_ctrl.sv
// ---- ysyx_25040105_exec_ctrl : FETCH/WAIT/EXEC/COMMIT sequencer with ebreak halt (rev 1.0) ----
`default_nettype none

module ysyx_25040105_exec_ctrl
  import ysyx_25040105_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        run_i,
  input  logic [31:0] pc_i,
  output logic        imem_req_valid_o,
  output logic [31:0] imem_req_addr_o,
  input  logic        imem_req_ready_i,
  input  logic        imem_rsp_valid_i,
  input  logic [31:0] imem_rsp_data_i,
  output logic        imem_rsp_ready_o,
  output logic [31:0] inst_o,
  input  logic        dec_reg_wen_i,
  input  logic [31:0] a0_i,
  output logic        pc_wen_o,
  output logic        rf_wen_o,
  output logic        halted_o,
  output logic [1:0]  halt_code_o,
  output logic [63:0] cycle_cnt_o,
  output logic [63:0] instret_o
);

  localparam int unsigned      WCW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam bit               TO_EN     = (TIMEOUT != 0);
  localparam logic [WCW-1:0]   WAIT_LAST = WCW'(TIMEOUT - 1);

  state_e         state_q;
  logic           req_valid_q;
  logic           rsp_ready_q;
  logic           pc_wen_q;
  logic           halted_q;
  logic [1:0]     halt_code_q;
  logic [31:0]    inst_q;
  logic [WCW-1:0] wait_cnt_q;
  logic           is_ebreak;

  assign is_ebreak = (inst_q == INST_EBREAK);

  // Strobe registers are loaded with the value belonging to the state being entered,
  // so every strobe is a clean flop output aligned with its state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      req_valid_q <= 1'b0;
      rsp_ready_q <= 1'b0;
      pc_wen_q    <= 1'b0;
      halted_q    <= 1'b0;
      halt_code_q <= HALT_NONE;
      inst_q      <= INST_NOP;
      wait_cnt_q  <= '0;
    end else begin
      req_valid_q <= 1'b0;
      rsp_ready_q <= 1'b0;
      pc_wen_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (run_i) begin
            state_q     <= ST_FETCH;
            req_valid_q <= 1'b1;
          end
        end
        ST_FETCH: begin
          if (imem_req_ready_i) begin
            state_q     <= ST_WAIT;
            rsp_ready_q <= 1'b1;
            wait_cnt_q  <= '0;
          end else begin
            req_valid_q <= 1'b1;
          end
        end
        ST_WAIT: begin
          // A response arriving on the last allowed cycle still wins over the timeout.
          if (imem_rsp_valid_i) begin
            inst_q  <= imem_rsp_data_i;
            state_q <= ST_EXEC;
          end else if (TO_EN && (wait_cnt_q == WAIT_LAST)) begin
            state_q     <= ST_HALT;
            halted_q    <= 1'b1;
            halt_code_q <= HALT_TIMEOUT;
          end else begin
            wait_cnt_q  <= wait_cnt_q + WCW'(1);
            rsp_ready_q <= 1'b1;
          end
        end
        ST_EXEC: begin
          state_q  <= ST_COMMIT;
          pc_wen_q <= !is_ebreak;
        end
        ST_COMMIT: begin
          if (is_ebreak) begin
            state_q     <= ST_HALT;
            halted_q    <= 1'b1;
            halt_code_q <= (a0_i == 32'd0) ? HALT_GOOD : HALT_BAD;
          end else if (run_i) begin
            state_q     <= ST_FETCH;
            req_valid_q <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_HALT: begin
          state_q <= ST_HALT;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign imem_req_valid_o = req_valid_q;
  assign imem_req_addr_o  = pc_i;
  assign imem_rsp_ready_o = rsp_ready_q;
  assign inst_o           = inst_q;
  assign pc_wen_o         = pc_wen_q;
  assign rf_wen_o         = pc_wen_q & dec_reg_wen_i;
  assign halted_o         = halted_q;
  assign halt_code_o      = halt_code_q;

  ysyx_25040105_perf_cnt u_perf_cnt (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .inc_cycle_i (state_q != ST_HALT),
    .inc_inst_i  (state_q == ST_COMMIT),
    .freeze_i    (halted_q),
    .cycle_cnt_o (cycle_cnt_o),
    .instret_o   (instret_o)
  );

endmodule

`default_nettype wire

// File: tb/tb_ysyx_25040105_exec_ctrl.sv
// ---- tb_ysyx_25040105_exec_ctrl : timeline-model bench for the exec sequencer (rev 1.0) ----
`default_nettype none

module tb_ysyx_25040105_exec_ctrl;

  localparam int          MAXC   = 512;
  localparam int          TO     = 8;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] ADDI1  = 32'h0050_0093;
  localparam logic [31:0] ADDI2  = 32'h0030_8113;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        run = 1'b0;
  logic [31:0] pc = 32'd0;
  logic        req_ready = 1'b0;
  logic        rsp_valid = 1'b0;
  logic [31:0] rsp_data = 32'd0;
  logic        dec_wen = 1'b0;
  logic [31:0] a0 = 32'd0;
  logic        req_valid, rsp_ready, pc_wen, rf_wen, halted;
  logic [31:0] req_addr, inst;
  logic [1:0]  halt_code;
  logic [63:0] cycle_cnt, instret;

  always #5 clk = ~clk;

  ysyx_25040105_exec_ctrl #(.TIMEOUT(TO)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_ni),
    .run_i            (run),
    .pc_i             (pc),
    .imem_req_valid_o (req_valid),
    .imem_req_addr_o  (req_addr),
    .imem_req_ready_i (req_ready),
    .imem_rsp_valid_i (rsp_valid),
    .imem_rsp_data_i  (rsp_data),
    .imem_rsp_ready_o (rsp_ready),
    .inst_o           (inst),
    .dec_reg_wen_i    (dec_wen),
    .a0_i             (a0),
    .pc_wen_o         (pc_wen),
    .rf_wen_o         (rf_wen),
    .halted_o         (halted),
    .halt_code_o      (halt_code),
    .cycle_cnt_o      (cycle_cnt),
    .instret_o        (instret)
  );

  // Per-cycle stimulus plan and expected outputs.
  logic        p_run [MAXC];
  logic [31:0] p_pc  [MAXC];
  logic        p_rqr [MAXC];
  logic        p_rsv [MAXC];
  logic [31:0] p_rsd [MAXC];
  logic        p_dw  [MAXC];
  logic [31:0] p_a0  [MAXC];
  logic        e_rv  [MAXC];
  logic        e_rr  [MAXC];
  logic        e_pw  [MAXC];
  logic        e_rw  [MAXC];
  logic [31:0] e_inst[MAXC];
  logic        e_halt[MAXC];
  logic [1:0]  e_code[MAXC];
  logic [63:0] e_cyc [MAXC];
  logic [63:0] e_ret [MAXC];
  logic        m_ex  [MAXC];
  logic [31:0] m_word[MAXC];
  logic        m_cm  [MAXC];
  int          n_cyc;

  int errs = 0;
  int checks = 0;
  int cyc = 0;
  int obs_pw = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // Builds a program timeline from instruction latencies: each instruction spends
  // 1+r cycles requesting, 1+s cycles waiting, one settle cycle and one commit cycle.
  task automatic build(input int ni, input bit dir, input logic [31:0] a0v,
                       input bit end_to, input int fr, input int fs);
    int c, r, s, g, hc;
    logic [31:0] w, pcv, iv;
    logic [1:0]  code;
    logic [63:0] ret;
    for (int k = 0; k < MAXC; k++) begin
      p_run[k] = 1'b1;
      p_pc[k]  = $urandom;
      p_rqr[k] = dir ? 1'b1 : 1'($urandom_range(0, 1));
      p_rsv[k] = dir ? 1'b1 : 1'($urandom_range(0, 1));
      p_rsd[k] = $urandom;
      p_dw[k]  = dir ? 1'b1 : 1'($urandom_range(0, 1));
      p_a0[k]  = dir ? a0v : (($urandom_range(0, 1) == 0) ? 32'd0 : $urandom);
      e_rv[k] = 1'b0; e_rr[k] = 1'b0; e_pw[k] = 1'b0; e_rw[k] = 1'b0;
      m_ex[k] = 1'b0; m_cm[k] = 1'b0; m_word[k] = 32'd0;
    end
    c = 1; hc = MAXC - 8; code = 2'd0;
    for (int i = 0; i < ni; i++) begin
      r = dir ? 0 : ((fr >= 0) ? fr : int'($urandom_range(0, 3)));
      s = dir ? 0 : ((fs >= 0) ? fs : int'($urandom_range(0, TO - 1)));
      if (dir) w = (i == 0) ? ADDI1 : ((i == 1) ? ADDI2 : EBREAK);
      else begin
        w = $urandom;
        if (w == EBREAK) w = NOP;
        if (i == ni - 1) w = EBREAK;
      end
      pcv = $urandom & 32'hFFFF_FFFC;
      for (int j = 0; j <= r; j++) begin
        p_pc[c+j] = pcv; p_rqr[c+j] = (j == r); e_rv[c+j] = 1'b1;
      end
      c += r + 1;
      if (end_to && i == ni - 1) begin
        for (int j = 0; j < TO; j++) begin e_rr[c+j] = 1'b1; p_rsv[c+j] = 1'b0; end
        hc = c + TO; code = 2'd3;
        break;
      end
      for (int j = 0; j <= s; j++) begin
        e_rr[c+j] = 1'b1; p_rsv[c+j] = (j == s);
        if (j == s) p_rsd[c+j] = w;
      end
      c += s + 1;
      m_ex[c] = 1'b1; m_word[c] = w; m_cm[c+1] = 1'b1;
      if (w == EBREAK) begin
        hc = c + 2; code = (p_a0[c+1] == 32'd0) ? 2'd1 : 2'd2;
        break;
      end
      e_pw[c+1] = 1'b1; e_rw[c+1] = p_dw[c+1];
      g = (dir || $urandom_range(0, 3) != 0) ? 0 : int'($urandom_range(1, 3));
      if (g > 0) for (int j = 0; j <= g; j++) p_run[c+j] = 1'b0;
      c += 2 + g;
    end
    n_cyc = hc + 4;
    iv = NOP; ret = 64'd0;
    for (int k = 0; k < n_cyc; k++) begin
      if (m_ex[k]) iv = m_word[k];
      e_inst[k] = iv;
      e_ret[k]  = ret;
      if (k < hc && m_cm[k]) ret++;
      e_cyc[k]  = (k < hc) ? 64'(k) : 64'(hc);
      e_halt[k] = (k >= hc);
      e_code[k] = (k >= hc) ? code : 2'd0;
    end
  endtask

  task automatic drive(input int k);
    run = p_run[k]; pc = p_pc[k]; req_ready = p_rqr[k]; rsp_valid = p_rsv[k];
    rsp_data = p_rsd[k]; dec_wen = p_dw[k]; a0 = p_a0[k];
  endtask

  task automatic run_prog();
    obs_pw = 0;
    rst_ni = 1'b0;
    drive(0);
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;
    for (int k = 0; k < n_cyc; k++) begin
      cyc = k;
      drive(k);
      @(negedge clk);
      check("req_valid", 64'(req_valid), 64'(e_rv[k]));
      if (e_rv[k]) check("req_addr", 64'(req_addr), 64'(p_pc[k]));
      check("rsp_ready", 64'(rsp_ready), 64'(e_rr[k]));
      check("pc_wen", 64'(pc_wen), 64'(e_pw[k]));
      check("rf_wen", 64'(rf_wen), 64'(e_rw[k]));
      check("inst", 64'(inst), 64'(e_inst[k]));
      check("halted", 64'(halted), 64'(e_halt[k]));
      check("halt_code", 64'(halt_code), 64'(e_code[k]));
      check("cycle_cnt", cycle_cnt, e_cyc[k]);
      check("instret", instret, e_ret[k]);
      if (pc_wen) obs_pw++;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    build(3, 1'b1, 32'd0, 1'b0, -1, -1); run_prog();
    build(3, 1'b1, 32'd7, 1'b0, -1, -1); run_prog();
    check("pc_wen_pulses", 64'(obs_pw), 64'd2);
    build(3, 1'b0, 32'd0, 1'b0, 3, 2);     run_prog();
    build(4, 1'b0, 32'd0, 1'b0, -1, TO-1); run_prog();
    build(2, 1'b0, 32'd0, 1'b1, -1, -1);   run_prog();
    for (int n = 0; n < 6; n++) begin
      build(int'($urandom_range(2, 8)), 1'b0, 32'd0, ($urandom_range(0, 3) == 0), -1, -1);
      run_prog();
    end

    // Asynchronous reset while halted with a non-nop instruction latched.
    cyc = -1;
    #2 rst_ni = 1'b0;
    #1;
    check("async_halted", 64'(halted), 64'd0);
    check("async_code", 64'(halt_code), 64'd0);
    check("async_inst", 64'(inst), 64'(NOP));
    check("async_cycle", cycle_cnt, 64'd0);
    check("async_instret", instret, 64'd0);

    // Reset in WAIT, then a late response after release must be ignored.
    @(posedge clk); #1;
    run = 1'b1; req_ready = 1'b1; rsp_valid = 1'b0; pc = 32'h8000_0000;
    rst_ni = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    check("wait_rsp_ready", 64'(rsp_ready), 64'd1);
    #2 rst_ni = 1'b0;
    #1;
    check("rst_rsp_ready", 64'(rsp_ready), 64'd0);
    @(posedge clk); #1;
    run = 1'b0; pc = 32'd0; dec_wen = 1'b0; req_ready = 1'b0; rst_ni = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc = k;
      rsp_valid = 1'b1; rsp_data = $urandom;
      @(negedge clk);
      check("late_rsp_ready", 64'(rsp_ready), 64'd0);
      check("late_req_valid", 64'(req_valid), 64'd0);
      check("late_inst", 64'(inst), 64'(NOP));
      check("late_strobes", {62'd0, pc_wen, rf_wen}, 64'd0);
      check("late_halt", {61'd0, halted, halt_code}, 64'd0);
      check("late_addr", 64'(req_addr), 64'd0);
      check("late_cycle", cycle_cnt, 64'(k));
      check("late_instret", instret, 64'd0);
      @(posedge clk); #1;
    end
    rsp_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

`default_nettype wire
